// File: rtl/dct_4pt_pkg.sv
// dct_pkg: shared sample/coefficient types, transform constants and output saturation
package dct_pkg;
  typedef logic signed [7:0] sample_t;
  typedef logic signed [9:0] coef_t;
  localparam logic signed [19:0] C1 = 20'sd167;
  localparam logic signed [19:0] C3 = 20'sd69;
  localparam logic signed [19:0] K0 = 20'sd32;
  localparam logic signed [19:0] K1 = 20'sd42;
  localparam logic signed [19:0] K3 = 20'sd17;
  localparam logic signed [19:0] RND = 20'sd64;
  localparam int SH = 7;
  function automatic sample_t sat8(input logic signed [19:0] v);
    return v > 20'sd127 ? sample_t'(8'h7f) : v < -20'sd128 ? sample_t'(8'h80) : sample_t'(v);
  endfunction
endpackage

// File: rtl/dct_4pt_if.sv
// dct_4pt_if: sample row in, forward coefficients and reconstructed row out
interface dct_4pt_if;
  import dct_pkg::*;
  logic    valid_i;
  sample_t dt_i [4];
  logic    dir_valid_o;
  coef_t   dt_dir_o [4];
  logic    inv_valid_o;
  sample_t dt_inv_o [4];
  modport master (output valid_i, dt_i, input dir_valid_o, dt_dir_o, inv_valid_o, dt_inv_o);
  modport slave (input valid_i, dt_i, output dir_valid_o, dt_dir_o, inv_valid_o, dt_inv_o);
endinterface

// File: rtl/dct_4pt_inv.sv
// dct_4pt_inv: combinational 4-point inverse DCT butterfly with 8-bit saturation
module dct_4pt_inv
  import dct_pkg::*;
(
  input  coef_t   y [4],
  output sample_t x [4]
);
  logic signed [19:0] e, f, g, h;
  // even/odd recombination, rounded back to the sample scale and clipped
  always_comb begin
    e = 20'(y[0]) + 20'(y[2]);
    f = 20'(y[0]) - 20'(y[2]);
    g = K1 * 20'(y[1]) + K3 * 20'(y[3]);
    h = K3 * 20'(y[1]) - K1 * 20'(y[3]);
    x[0] = sat8((K0 * e + g + RND) >>> SH);
    x[1] = sat8((K0 * f + h + RND) >>> SH);
    x[2] = sat8((K0 * f - h + RND) >>> SH);
    x[3] = sat8((K0 * e - g + RND) >>> SH);
  end
endmodule

// File: rtl/dct_4pt.sv
// dct_4pt: pipelined 4-point DCT-II with optional inverse round-trip stage (enabled by DCT_INV_EN)
module dct_4pt
  import dct_pkg::*;
(
  input logic       clk_i,
  input logic       rst_ni,
  dct_4pt_if.slave  bus
);
  logic signed [8:0] a, b, c, d;
  coef_t y [4];
  // forward butterfly; Y0/Y2 are exact, odd terms use Q7 rotation with rounding
  always_comb begin
    a = 9'(bus.dt_i[0]) + 9'(bus.dt_i[3]);
    b = 9'(bus.dt_i[1]) + 9'(bus.dt_i[2]);
    c = 9'(bus.dt_i[0]) - 9'(bus.dt_i[3]);
    d = 9'(bus.dt_i[1]) - 9'(bus.dt_i[2]);
    y[0] = 10'(a) + 10'(b);
    y[2] = 10'(a) - 10'(b);
    y[1] = coef_t'((C1 * 20'(c) + C3 * 20'(d) + RND) >>> SH);
    y[3] = coef_t'((C3 * 20'(c) - C1 * 20'(d) + RND) >>> SH);
  end
  // coefficient register: loads on valid rows, holds otherwise
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      bus.dir_valid_o <= 1'b0;
      bus.dt_dir_o <= '{default: '0};
    end else begin
      bus.dir_valid_o <= bus.valid_i;
      if (bus.valid_i) bus.dt_dir_o <= y;
    end
`ifdef DCT_INV_EN
  sample_t xr [4];
  dct_4pt_inv u_inv (.y(bus.dt_dir_o), .x(xr));
  // reconstruction register: loads when fresh coefficients are present
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      bus.inv_valid_o <= 1'b0;
      bus.dt_inv_o <= '{default: '0};
    end else begin
      bus.inv_valid_o <= bus.dir_valid_o;
      if (bus.dir_valid_o) bus.dt_inv_o <= xr;
    end
`else
  // inverse stage absent: reconstruction outputs are held at zero
  always_comb begin
    bus.inv_valid_o = 1'b0;
    for (int k = 0; k < 4; k++) bus.dt_inv_o[k] = '0;
  end
`endif
endmodule

// File: tb/tb_dct_4pt.sv
// tb_dct_4pt: directed self-checking bench for dct_4pt
module tb_dct_4pt;
  import dct_pkg::*;
  typedef sample_t srow_t [4];
  typedef coef_t crow_t [4];
`ifdef DCT_INV_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  dct_4pt_if bus();
  dct_4pt dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [39:0] pk10(input crow_t r);
    return {r[0], r[1], r[2], r[3]};
  endfunction
  function automatic logic [31:0] pk8(input srow_t r);
    return {r[0], r[1], r[2], r[3]};
  endfunction
  function automatic logic [31:0] exp_inv(input srow_t r);
    return INV ? pk8(r) : 32'h0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.valid_i = 1'b0;
    bus.dt_i = '{0, 0, 0, 0};
    rst_n = 1'b0;
    repeat (2) tick;
    checks++;
    if ({bus.dir_valid_o, bus.inv_valid_o} !== 2'b00) begin
      errs++;
      $display("FAIL reset_valids: got %b want 00", {bus.dir_valid_o, bus.inv_valid_o});
    end
    checks++;
    if (pk10(bus.dt_dir_o) !== 40'h0) begin
      errs++;
      $display("FAIL reset_dir: got %p want all 0", bus.dt_dir_o);
    end
    checks++;
    if (pk8(bus.dt_inv_o) !== 32'h0) begin
      errs++;
      $display("FAIL reset_inv: got %p want all 0", bus.dt_inv_o);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_row(input string nm, input srow_t x, input crow_t ed);
    bus.dt_i = x;
    bus.valid_i = 1'b1;
    tick;
    bus.valid_i = 1'b0;
    checks++;
    if (bus.dir_valid_o !== 1'b1) begin
      errs++;
      $display("FAIL %s dir_valid: got %b want 1", nm, bus.dir_valid_o);
    end
    checks++;
    if (pk10(bus.dt_dir_o) !== pk10(ed)) begin
      errs++;
      $display("FAIL %s dir: got %p want %p", nm, bus.dt_dir_o, ed);
    end
    tick;
    checks++;
    if ({bus.dir_valid_o, bus.inv_valid_o} !== {1'b0, INV}) begin
      errs++;
      $display("FAIL %s valids: got %b want %b", nm, {bus.dir_valid_o, bus.inv_valid_o}, {1'b0, INV});
    end
    checks++;
    if (pk8(bus.dt_inv_o) !== exp_inv(x)) begin
      errs++;
      $display("FAIL %s inv: got %p want %h", nm, bus.dt_inv_o, exp_inv(x));
    end
  endtask

  task automatic test_back_to_back;
    srow_t m = '{-128, -128, -128, -128};
    srow_t p = '{127, 127, 127, 127};
    crow_t dm = '{-512, 0, 0, 0};
    crow_t dp = '{508, 0, 0, 0};
    bus.dt_i = m;
    bus.valid_i = 1'b1;
    tick;
    checks++;
    if (pk10(bus.dt_dir_o) !== pk10(dm) || bus.dir_valid_o !== 1'b1) begin
      errs++;
      $display("FAIL b2b_dir_min: got %p v=%b want %p v=1", bus.dt_dir_o, bus.dir_valid_o, dm);
    end
    bus.dt_i = p;
    tick;
    bus.valid_i = 1'b0;
    checks++;
    if (pk10(bus.dt_dir_o) !== pk10(dp) || bus.dir_valid_o !== 1'b1) begin
      errs++;
      $display("FAIL b2b_dir_max: got %p v=%b want %p v=1", bus.dt_dir_o, bus.dir_valid_o, dp);
    end
    checks++;
    if (pk8(bus.dt_inv_o) !== exp_inv(m) || bus.inv_valid_o !== INV) begin
      errs++;
      $display("FAIL b2b_inv_min: got %p v=%b want %h v=%b", bus.dt_inv_o, bus.inv_valid_o, exp_inv(m), INV);
    end
    tick;
    checks++;
    if (pk8(bus.dt_inv_o) !== exp_inv(p) || bus.inv_valid_o !== INV || bus.dir_valid_o !== 1'b0) begin
      errs++;
      $display("FAIL b2b_inv_max: got %p v=%b dv=%b want %h v=%b dv=0", bus.dt_inv_o, bus.inv_valid_o, bus.dir_valid_o, exp_inv(p), INV);
    end
    tick;
  endtask

  task automatic test_extreme;
    crow_t ed = '{-2, 195, 0, 470};
    srow_t r = '{126, -128, 127, -127};
    bus.dt_i = '{127, -128, 127, -128};
    bus.valid_i = 1'b1;
    tick;
    bus.valid_i = 1'b0;
    checks++;
    if (pk10(bus.dt_dir_o) !== pk10(ed)) begin
      errs++;
      $display("FAIL extreme_dir: got %p want %p", bus.dt_dir_o, ed);
    end
    tick;
    for (int k = 0; k < 4; k++) begin
      int df;
      df = int'(bus.dt_inv_o[k]) - (INV ? int'(r[k]) : 0);
      checks++;
      if (df > 1 || df < -1) begin
        errs++;
        $display("FAIL extreme_inv%0d: got %0d want %0d (+/-1)", k, bus.dt_inv_o[k], INV ? int'(r[k]) : 0);
      end
    end
    tick;
  endtask

  task automatic test_gap_and_reset;
    srow_t ra = '{5, 10, 20, 0};
    srow_t rb = '{39, 83, 80, 6};
    crow_t da = '{35, 1, -25, 16};
    crow_t db = '{208, 45, -118, 14};
    bus.dt_i = ra;
    bus.valid_i = 1'b1;
    tick;
    bus.valid_i = 1'b0;
    bus.dt_i = rb;
    checks++;
    if (bus.dir_valid_o !== 1'b1 || pk10(bus.dt_dir_o) !== pk10(da)) begin
      errs++;
      $display("FAIL gap_first: got %p v=%b want %p v=1", bus.dt_dir_o, bus.dir_valid_o, da);
    end
    tick;
    checks++;
    if (bus.dir_valid_o !== 1'b0 || pk10(bus.dt_dir_o) !== pk10(da)) begin
      errs++;
      $display("FAIL gap_hold: got %p v=%b want %p v=0", bus.dt_dir_o, bus.dir_valid_o, da);
    end
    bus.valid_i = 1'b1;
    tick;
    bus.valid_i = 1'b0;
    checks++;
    if (bus.dir_valid_o !== 1'b1 || pk10(bus.dt_dir_o) !== pk10(db)) begin
      errs++;
      $display("FAIL gap_second: got %p v=%b want %p v=1", bus.dt_dir_o, bus.dir_valid_o, db);
    end
    checks++;
    if (bus.inv_valid_o !== 1'b0 || pk8(bus.dt_inv_o) !== exp_inv(ra)) begin
      errs++;
      $display("FAIL gap_inv_hold: got %p v=%b want %h v=0", bus.dt_inv_o, bus.inv_valid_o, exp_inv(ra));
    end
    tick;
    checks++;
    if (bus.inv_valid_o !== INV || pk8(bus.dt_inv_o) !== exp_inv(rb)) begin
      errs++;
      $display("FAIL gap_inv_second: got %p v=%b want %h v=%b", bus.dt_inv_o, bus.inv_valid_o, exp_inv(rb), INV);
    end
    bus.dt_i = ra;
    bus.valid_i = 1'b1;
    tick;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.dir_valid_o, bus.inv_valid_o} !== 2'b00 || pk10(bus.dt_dir_o) !== 40'h0 || pk8(bus.dt_inv_o) !== 32'h0) begin
      errs++;
      $display("FAIL async_reset: got dir=%p inv=%p v=%b want all 0", bus.dt_dir_o, bus.dt_inv_o, {bus.dir_valid_o, bus.inv_valid_o});
    end
    bus.valid_i = 1'b0;
    tick;
    rst_n = 1'b1;
    repeat (2) tick;
    checks++;
    if ({bus.dir_valid_o, bus.inv_valid_o} !== 2'b00 || pk10(bus.dt_dir_o) !== 40'h0 || pk8(bus.dt_inv_o) !== 32'h0) begin
      errs++;
      $display("FAIL post_reset_idle: got dir=%p inv=%p v=%b want all 0", bus.dt_dir_o, bus.dt_inv_o, {bus.dir_valid_o, bus.inv_valid_o});
    end
  endtask

  initial begin
    test_reset;
    test_row("row_small", '{5, 10, 20, 0}, '{35, 1, -25, 16});
    test_row("row_mixed", '{39, 83, 80, 6}, '{208, 45, -118, 14});
    test_back_to_back;
    test_extreme;
    test_gap_and_reset;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
